dma_channel_dispatcher: RTL and testbench

Per-channel request collector and transfer dispatcher sitting directly downstream of the DMA round-robin arbiter. It latches channel start requests into a pending vector, presents that vector to the arbiter, commits the arbiter's one-hot grant with a single `arbGrantEn` pulse, and hands the winning channel ID to the transfer engine over a valid/ready start handshake. It then waits for transfer completion and reports a per-channel done or error pulse.

---
 rtl/dma_channel_dispatcher.sv | 107 ++++++++++
 tb/tb_dma_channel_dispatcher.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/dma_channel_dispatcher.sv
// Collects per-channel DMA start requests, commits one arbiter grant per transfer,
// hands the winning channel to the transfer engine and reports per-channel completion.
module dma_channel_dispatcher #(
  parameter int NO_OF_CHANNELS = 4,
  parameter int CHAN_ID_WIDTH  = 2
) (
  input  logic                      clock,
  input  logic                      resetn,
  input  logic [NO_OF_CHANNELS-1:0] chanReq,
  input  logic [NO_OF_CHANNELS-1:0] chanClr,
  output logic [NO_OF_CHANNELS-1:0] arbReq,
  input  logic [NO_OF_CHANNELS-1:0] arbGrant,
  output logic                      arbGrantEn,
  output logic                      startValid,
  input  logic                      startReady,
  output logic [CHAN_ID_WIDTH-1:0]  startChan,
  input  logic                      xferDone,
  input  logic                      xferErr,
  output logic [NO_OF_CHANNELS-1:0] chanDone,
  output logic [NO_OF_CHANNELS-1:0] chanErr,
  output logic                      busy
);

  typedef enum logic [1:0] {IDLE, START, WAIT} state_t;

  state_t                      state_q, state_d;
  logic [NO_OF_CHANNELS-1:0]   pend_q, pend_d;
  logic [NO_OF_CHANNELS-1:0]   grant_q, grant_d;
  logic [CHAN_ID_WIDTH-1:0]    start_chan_q, start_chan_d;
  logic [NO_OF_CHANNELS-1:0]   chan_done_q, chan_done_d;
  logic [NO_OF_CHANNELS-1:0]   chan_err_q, chan_err_d;
  logic [NO_OF_CHANNELS-1:0]   grant_low;
  logic                        handshake;

  // Lowest set bit wins so a malformed multi-hot grant still yields a one-hot grantReg.
  function automatic logic [CHAN_ID_WIDTH-1:0] encode_low(input logic [NO_OF_CHANNELS-1:0] vec);
    encode_low = '0;
    for (int i = NO_OF_CHANNELS - 1; i >= 0; i--) begin
      if (vec[i]) encode_low = CHAN_ID_WIDTH'(i);
    end
  endfunction

  assign grant_low = arbGrant & (~arbGrant + NO_OF_CHANNELS'(1));

  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    start_chan_d = start_chan_q;
    chan_done_d  = '0;
    chan_err_d   = '0;
    arbGrantEn   = 1'b0;
    startValid   = 1'b0;
    handshake    = 1'b0;
    case (state_q)
      IDLE: begin
        arbGrantEn = |pend_q;
        if (arbGrantEn && (|arbGrant)) begin
          grant_d      = grant_low;
          start_chan_d = encode_low(arbGrant);
          state_d      = START;
        end
      end
      START: begin
        startValid = 1'b1;
        if (startReady) begin
          handshake = 1'b1;
          state_d   = WAIT;
        end
      end
      WAIT: begin
        if (xferDone) begin
          if (xferErr) chan_err_d  = grant_q;
          else         chan_done_d = grant_q;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    // A new request in the same cycle as any clear keeps the bit set.
    pend_d = (pend_q & ~(chanClr | (handshake ? grant_q : '0))) | chanReq;
  end

  always_ff @(posedge clock) begin
    if (!resetn) begin
      state_q      <= IDLE;
      pend_q       <= '0;
      grant_q      <= '0;
      start_chan_q <= '0;
      chan_done_q  <= '0;
      chan_err_q   <= '0;
    end else begin
      state_q      <= state_d;
      pend_q       <= pend_d;
      grant_q      <= grant_d;
      start_chan_q <= start_chan_d;
      chan_done_q  <= chan_done_d;
      chan_err_q   <= chan_err_d;
    end
  end

  assign arbReq    = pend_q;
  assign startChan = start_chan_q;
  assign chanDone  = chan_done_q;
  assign chanErr   = chan_err_q;
  assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_dma_channel_dispatcher.sv
// Scoreboard bench for dma_channel_dispatcher with a round-robin arbiter model attached.
module tb_dma_channel_dispatcher;

  logic       clock = 1'b0;
  logic       resetn = 1'b0;
  logic [3:0] chanReq = '0, chanClr = '0, arbReq, arb_grant, chanDone, chanErr;
  logic       arbGrantEn, startValid, startReady = 1'b0, xferDone = 1'b0, xferErr = 1'b0, busy;
  logic [1:0] startChan;

  int checks = 0;
  int errors = 0;
  int gnt_cnt = 0;
  int ptr = 0;
  logic [1:0] start_q[$];
  logic [7:0] done_q[$];

  always #5 clock = ~clock;

  dma_channel_dispatcher #(.NO_OF_CHANNELS(4), .CHAN_ID_WIDTH(2)) dut (
    .clock(clock), .resetn(resetn), .chanReq(chanReq), .chanClr(chanClr),
    .arbReq(arbReq), .arbGrant(arb_grant), .arbGrantEn(arbGrantEn),
    .startValid(startValid), .startReady(startReady), .startChan(startChan),
    .xferDone(xferDone), .xferErr(xferErr), .chanDone(chanDone), .chanErr(chanErr),
    .busy(busy)
  );

  // Round-robin arbiter: search starts at ptr, ptr moves past the winner on arbGrantEn.
  always_comb begin
    arb_grant = '0;
    for (int k = 0; k < 4; k++) begin
      if (arb_grant == '0 && arbReq[(ptr + k) % 4]) arb_grant[(ptr + k) % 4] = 1'b1;
    end
  end

  always @(posedge clock) begin
    if (!resetn) ptr <= 0;
    else if (arbGrantEn) begin
      for (int k = 0; k < 4; k++) if (arb_grant[k]) ptr <= (k + 1) % 4;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Monitor: pops expected start channel / completion pulse whenever the DUT presents one.
  always @(negedge clock) begin
    if (arbGrantEn) gnt_cnt++;
    if (startValid && startReady) begin
      if (start_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_start actual=%0d expected=none", startChan);
      end else chk("start_chan", {30'd0, startChan}, {30'd0, start_q.pop_front()});
    end
    if ((chanDone | chanErr) != 4'b0000) begin
      if (done_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_completion actual=%0h expected=none", {chanErr, chanDone});
      end else chk("completion_err_done", {24'd0, chanErr, chanDone}, {24'd0, done_q.pop_front()});
    end
  end

  task automatic step;
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset;
    resetn = 1'b0; chanReq = '0; chanClr = '0; xferDone = 1'b0; xferErr = 1'b0;
    repeat (2) step();
    resetn = 1'b1;
  endtask

  task automatic wait_wait;
    for (int i = 0; i < 30; i++) begin
      @(negedge clock);
      if (busy && !startValid) return;
    end
    checks++; errors++;
    $display("FAIL wait_state_timeout actual=not_reached expected=WAIT");
  endtask

  task automatic xfer(input logic err);
    xferDone = 1'b1; xferErr = err;
    step();
    xferDone = 1'b0; xferErr = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running expected=finished");
    $fatal(1, "timeout");
  end

  initial begin
    // Single dispatch of channel 2 with exact cycle timing
    do_reset();
    startReady = 1'b1;
    chanReq = 4'b0100;
    start_q.push_back(2'd2); done_q.push_back({4'b0000, 4'b0100});
    @(negedge clock);
    chk("rst_arbReq", {28'd0, arbReq}, 32'd0);
    chk("rst_grantEn", {31'd0, arbGrantEn}, 32'd0);
    chk("rst_startValid", {31'd0, startValid}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done_err", {24'd0, chanErr, chanDone}, 32'd0);
    chk("rst_startChan", {30'd0, startChan}, 32'd0);
    step(); chanReq = '0;
    @(negedge clock);
    chk("c1_grantEn", {31'd0, arbGrantEn}, 32'd1);
    chk("c1_arbReq", {28'd0, arbReq}, 32'h4);
    step();
    @(negedge clock);
    chk("c2_startValid", {31'd0, startValid}, 32'd1);
    chk("c2_startChan", {30'd0, startChan}, 32'd2);
    step(); step(); step();
    xferDone = 1'b1;
    @(negedge clock);
    chk("c5_busy", {31'd0, busy}, 32'd1);
    step(); xferDone = 1'b0;
    @(negedge clock);
    chk("c6_idle", {31'd0, busy}, 32'd0);
    step();
    @(negedge clock);
    chk("c7_done_low", {28'd0, chanDone}, 32'd0);

    // All four channels at once: round-robin order 0,1,2,3
    do_reset();
    startReady = 1'b1;
    gnt_cnt = 0;
    chanReq = 4'b1111;
    for (int i = 0; i < 4; i++) begin
      start_q.push_back(2'(i));
      done_q.push_back({4'b0000, 4'b0001 << i});
    end
    step(); chanReq = '0;
    for (int i = 0; i < 4; i++) begin
      wait_wait();
      if (i == 3) chk("all4_pend_empty", {28'd0, arbReq}, 32'd0);
      xfer(1'b0);
    end
    repeat (3) step();
    chk("all4_grant_count", gnt_cnt, 32'd4);

    // Start stalled for 10 cycles
    do_reset();
    startReady = 1'b0;
    chanReq = 4'b0010;
    start_q.push_back(2'd1); done_q.push_back({4'b0000, 4'b0010});
    step(); chanReq = '0;
    step();
    for (int i = 0; i < 10; i++) begin
      @(negedge clock);
      chk("stall_valid", {31'd0, startValid}, 32'd1);
      chk("stall_chan", {30'd0, startChan}, 32'd1);
      chk("stall_no_grantEn", {31'd0, arbGrantEn}, 32'd0);
      step();
    end
    startReady = 1'b1;
    wait_wait();
    xfer(1'b0);
    repeat (2) step();

    // Set/clear collisions, cancelled channel 3, error completion, stray xferDone
    do_reset();
    startReady = 1'b0;
    chanReq = 4'b0001;
    start_q.push_back(2'd0); done_q.push_back({4'b0001, 4'b0000});
    start_q.push_back(2'd1); done_q.push_back({4'b0000, 4'b0010});
    step(); chanReq = '0;
    step(); chanReq = 4'b1010; chanClr = 4'b0010;
    step(); chanReq = '0; chanClr = 4'b1000;
    @(negedge clock);
    chk("collide_set_wins", {28'd0, arbReq}, 32'hB);
    step(); chanClr = '0;
    @(negedge clock);
    chk("clr_ch3", {28'd0, arbReq}, 32'h3);
    startReady = 1'b1;
    wait_wait();
    xfer(1'b1);
    wait_wait();
    xfer(1'b0);
    repeat (5) step();
    @(negedge clock);
    chk("no_ch3_idle", {31'd0, busy}, 32'd0);
    chk("no_ch3_pend", {28'd0, arbReq}, 32'd0);
    xfer(1'b1);
    @(negedge clock);
    chk("stray_done", {24'd0, chanErr, chanDone}, 32'd0);

    // Reset while in WAIT, then normal dispatch
    do_reset();
    startReady = 1'b1;
    chanReq = 4'b0100;
    start_q.push_back(2'd2);
    step(); chanReq = '0;
    wait_wait();
    resetn = 1'b0; xferDone = 1'b1;
    step();
    resetn = 1'b1; xferDone = 1'b0;
    @(negedge clock);
    chk("wrst_busy", {31'd0, busy}, 32'd0);
    chk("wrst_valid", {31'd0, startValid}, 32'd0);
    chk("wrst_arbReq", {28'd0, arbReq}, 32'd0);
    chk("wrst_grantEn", {31'd0, arbGrantEn}, 32'd0);
    chk("wrst_done_err", {24'd0, chanErr, chanDone}, 32'd0);
    chanReq = 4'b0001;
    start_q.push_back(2'd0); done_q.push_back({4'b0000, 4'b0001});
    step(); chanReq = '0;
    wait_wait();
    xfer(1'b0);
    repeat (3) step();
    chk("start_q_drained", start_q.size(), 32'd0);
    chk("done_q_drained", done_q.size(), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
